// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV64M multiply/divide unit for the EX stage.
// Multiplies use radix-2 shift-add, divides use restoring shift-subtract, both
// on operand magnitudes with a sign fixup when the result is registered.
// Build option MULDIV_FAST_MUL_EN: multiplies finish in one cycle through a
// combinational product; divides remain iterative.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q;
  logic [5:0]      cnt_q;
  logic [2:0]      f3_q;
  logic            w_q, neg_q;
  logic [XLEN-1:0] hi_q, lo_q, opnd_q, result_q;

  logic [2:0]      f3;
  logic            is_div, sgn1, sgn2, neg1, neg2, div0, ovf, neg_d;
  logic [XLEN-1:0] ext1, ext2, mag1, mag2, min_val, sp_hi, sp_lo;
  logic [XLEN:0]   mul_sum, rem_sh;
  logic [XLEN-1:0] hi_d, lo_d;

  // hi holds the product high half / remainder, lo the product low half / quotient
  function automatic logic [XLEN-1:0] finalize(input logic [2:0] fn, input logic w,
                                               input logic neg, input logic [XLEN-1:0] hi,
                                               input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   v;
    if (!fn[2]) begin
      p = neg ? -{hi, lo} : {hi, lo};
      v = (fn == 3'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    end else begin
      v = fn[1] ? hi : lo;
      if (neg) v = -v;
    end
    if (w) v = {{(XLEN-32){v[31]}}, v[31:0]};
    return v;
  endfunction

  // Decode the incoming op: operand narrowing, magnitudes and the single-cycle special cases
  always_comb begin
    f3      = (op[3] && !op[2]) ? 3'd0 : op[2:0];
    is_div  = f3[2];
    sgn1    = is_div ? !f3[0] : (f3 != 3'd3);
    sgn2    = is_div ? !f3[0] : !f3[1];
    ext1    = op[3] ? {{(XLEN-32){sgn1 & src1[31]}}, src1[31:0]} : src1;
    ext2    = op[3] ? {{(XLEN-32){sgn2 & src2[31]}}, src2[31:0]} : src2;
    neg1    = sgn1 & ext1[XLEN-1];
    neg2    = sgn2 & ext2[XLEN-1];
    mag1    = neg1 ? -ext1 : ext1;
    mag2    = neg2 ? -ext2 : ext2;
    min_val = op[3] ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div0    = is_div && (ext2 == '0);
    ovf     = is_div && !f3[0] && (ext1 == min_val) && (ext2 == '1);
    neg_d   = (is_div && f3[1]) ? neg1 : (neg1 ^ neg2);
    sp_hi   = div0 ? ext1 : '0;
    sp_lo   = div0 ? '1 : ext1;
  end

  // One multiply or divide iteration on the working registers
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh  = {hi_q, lo_q[XLEN-1]};
    if (!f3_q[2]) begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end else if (rem_sh >= {1'b0, opnd_q}) begin
      hi_d = XLEN'(rem_sh - {1'b0, opnd_q});
      lo_d = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_d = rem_sh[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], 1'b0};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_p;
  assign fast_p = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      w_q      <= 1'b0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else if (kill) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            f3_q   <= f3;
            w_q    <= op[3];
            neg_q  <= neg_d;
            opnd_q <= is_div ? mag2 : mag1;
            lo_q   <= is_div ? mag1 : mag2;
            hi_q   <= '0;
            cnt_q  <= '0;
            if (div0 || ovf) begin
              result_q <= finalize(f3, op[3], 1'b0, sp_hi, sp_lo);
              state_q  <= S_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!is_div) begin
              result_q <= finalize(f3, op[3], neg_d, fast_p[2*XLEN-1:XLEN], fast_p[XLEN-1:0]);
              state_q  <= S_DONE;
            end
`endif
            else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd63) begin
            result_q <= finalize(f3_q, w_q, neg_q, hi_d, lo_d);
            state_q  <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall  = ((state_q == S_IDLE) && start && !kill) || (state_q == S_CALC);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Testbench for ex_muldiv_unit: directed cases plus randomized traffic checked
// every cycle against an arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam logic [3:0] MUL = 4'd0, MULHU = 4'd3, DIV = 4'd4, DIVU = 4'd5;
  localparam logic [3:0] REM = 4'd6, REMU = 4'd7, DIVW = 4'd12;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
`ifdef MULDIV_FAST_MUL_EN
  localparam int unsigned MUL_LAT = 0;
`else
  localparam int unsigned MUL_LAT = 64;
`endif

  logic        clk, rst, start, kill, stall, busy, done;
  logic [3:0]  op;
  logic [63:0] src1, src2, result;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          chk_en = 0;

  ex_muldiv_unit #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op),
    .src1(src1), .src2(src2), .stall(stall), .busy(busy), .done(done),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic straight from the RV64M rules
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [127:0] p;
    logic [31:0]  a32, b32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (o[3]) begin
      case (o[2:0])
        3'd4: if (b32 == 0) r32 = '1;
              else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
              else r32 = $signed(a32) / $signed(b32);
        3'd5: r32 = (b32 == 0) ? '1 : a32 / b32;
        3'd6: if (b32 == 0) r32 = a32;
              else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
              else r32 = $signed(a32) % $signed(b32);
        3'd7: r32 = (b32 == 0) ? a32 : a32 % b32;
        default: r32 = a32 * b32;
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (o[2:0])
      3'd0: return a * b;
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      3'd4: if (b == 0) return '1;
            else if (a == MIN64 && b == '1) return a;
            else return $signed(a) / $signed(b);
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: if (b == 0) return a;
            else if (a == MIN64 && b == '1) return '0;
            else return $signed(a) % $signed(b);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges after the accepting edge until done is visible
  function automatic int unsigned ref_lat(input logic [3:0] o, input logic [63:0] a,
                                          input logic [63:0] b);
    if (o[2]) begin
      if (o[3]) begin
        if (b[31:0] == 0) return 0;
        if (!o[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 0;
      end else begin
        if (b == 0) return 0;
        if (!o[0] && a == MIN64 && b == '1) return 0;
      end
      return 64;
    end
    return MUL_LAT;
  endfunction

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 8))
      0: return 64'd0;
      1: return '1;
      2: return MIN64;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return 64'd0 - 64'($urandom_range(1, 20));
      6: return {$urandom, 32'd0};
      7: return {32'd0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one op in flight, done at a known cycle
  int unsigned cyc = 0;
  int unsigned m_done_cyc = 0;
  bit          m_active = 0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_result = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_active = 0;
      m_result = '0;
    end else if (kill) begin
      m_active = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active   = 1;
        m_done_cyc = cyc + ref_lat(op, src1, src2);
        m_pend     = ref_result(op, src1, src2);
      end
    end else if (cyc > m_done_cyc) begin
      m_active = 0;
    end
    if (m_active && cyc == m_done_cyc) m_result = m_pend;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",   64'(busy),  64'(m_active));
      chk("done",   64'(done),  64'(m_active && cyc == m_done_cyc));
      chk("stall",  64'(stall), 64'((!m_active && start && !kill) || (m_active && cyc < m_done_cyc)));
      chk("result", result, m_result);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_r, input int unsigned exp_lat, input string nm);
    int unsigned n;
    op = o; src1 = a; src2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (n = 0; n <= 70; n++) begin
      if (done) break;
      tick();
    end
    chk({nm, "_lat"}, 64'(n), 64'(exp_lat));
    chk({nm, "_res"}, result, exp_r);
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; src1 = '0; src2 = '0;
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", result, 64'd0);

    chk("pin_mul",   ref_result(MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("pin_mulhu", ref_result(MULHU, '1, '1), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("pin_div",   ref_result(DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("pin_rem",   ref_result(REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_divw",  ref_result(DIVW, 64'h8000_0000, '1), 64'hFFFF_FFFF_8000_0000);
    chk("pin_remu0", ref_result(REMU, 64'd5, 64'd0), 64'd5);
    chk("pin_lat0",  64'(ref_lat(DIVU, 64'd5, 64'd0)), 64'd0);

    run_op(MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT, "t1_mul");
    run_op(MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT, "t2_mulhu");
    run_op(DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, "t3_div");
    run_op(REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, "t3_rem");
    run_op(DIVW, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 0, "t3_divw");
    run_op(DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, "t4_divu0");
    run_op(REMU, 64'd5, 64'd0, 64'd5, 0, "t4_remu0");

    // kill mid-divide: no done, result keeps the REMU value
    op = DIV; src1 = 64'd100; src2 = 64'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_result", result, 64'd5);
    run_op(DIV, 64'd100, 64'd7, 64'd14, 64, "t5_after");

    // start together with kill is never accepted
    op = DIV; src1 = 64'd9; src2 = 64'd2; start = 1'b1; kill = 1'b1;
    tick();
    start = 1'b0; kill = 1'b0;
    chk("t6_kill_start", 64'(busy), 64'd0);

    // reset in the middle of a divide
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_stall", 64'(stall), 64'd0);
    chk("t6_rst_result", result, 64'd0);

    // randomized traffic, including starts while busy, kills and resets
    for (int i = 0; i < 12000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      kill  = ($urandom_range(0, 199) == 0);
      rst   = ($urandom_range(0, 999) == 0);
      op    = 4'($urandom_range(0, 15));
      src1  = rnd_opnd();
      src2  = rnd_opnd();
      tick();
    end
    start = 1'b0; kill = 1'b0; rst = 1'b0;
    repeat (70) tick();
    chk_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
